// File: rtl/rounding_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rounding_pipe
// Description : Multi-lane pipelined fixed-point narrowing unit. Drops the
//               (IN_WIDTH-OUT_WIDTH) LSBs of each lane with a per-beat
//               rounding mode, optionally saturates on overflow, and keeps a
//               sticky saturation event counter. Valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module rounding_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int LANES     = 4,
    parameter int SIGNED    = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [LANES*IN_WIDTH-1:0]  i_data,
    input  logic [1:0]                 i_mode,
    input  logic                       i_sat_en,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [LANES*OUT_WIDTH-1:0] o_data,
    output logic [LANES-1:0]           o_sat,
    output logic [CNT_WIDTH-1:0]       sat_count,
    input  logic                       cnt_clr
);

    localparam int D  = IN_WIDTH - OUT_WIDTH;
    localparam int EW = IN_WIDTH + 1;

    localparam logic       IS_SIGNED  = (SIGNED != 0);
    localparam logic [1:0] MODE_TRUNC = 2'b00;
    localparam logic [1:0] MODE_HALFU = 2'b01;
    localparam logic [1:0] MODE_CONV  = 2'b10;
    localparam logic [1:0] MODE_HALFA = 2'b11;

    localparam logic [EW-1:0]        C_HALF    = {{(EW-D){1'b0}}, 1'b1, {(D-1){1'b0}}};
    localparam logic [EW-1:0]        C_HALF_M1 = {{(EW-D+1){1'b0}}, {(D-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] C_SMAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] C_SMIN    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] C_UMAX    = {OUT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Pipeline control state
    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_sat_en_d, s1_sat_en_q;
    logic                 s2_valid_d, s2_valid_q;
    logic [CNT_WIDTH-1:0] sat_count_d, sat_count_q;

    logic s2_load;
    logic s1_load;
    logic s1_take;
    logic s2_take;

    // Stage advance: each stage moves when its downstream slot frees this cycle
    always_comb begin
        s2_load = !s2_valid_q || o_ready;
        s1_load = !s1_valid_q || s2_load;
        s1_take = s1_load && i_valid;
        s2_take = s2_load && s1_valid_q;
        i_ready = s1_load;
        o_valid = s2_valid_q;
        sat_count = sat_count_q;
    end

    // Next-state for stage valids, travelling sat_en and the event counter
    always_comb begin
        s1_valid_d  = s1_load ? i_valid : s1_valid_q;
        s1_sat_en_d = s1_take ? i_sat_en : s1_sat_en_q;
        s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
        sat_count_d = sat_count_q;
        if (cnt_clr) begin
            sat_count_d = '0;
        end else if (s2_valid_q && o_ready && (|o_sat) && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + C_CNT_ONE;
        end
    end

    // Control registers; a reset discards anything in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s1_sat_en_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sat_en_q <= s1_sat_en_d;
            s2_valid_q  <= s2_valid_d;
            sat_count_q <= sat_count_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [IN_WIDTH-1:0]  lane_in;
            logic [EW-1:0]        lane_x;
            logic [EW-1:0]        lane_add;
            logic [EW-1:0]        sum_d, sum_q;
            logic [OUT_WIDTH:0]   r;
            logic                 ovf;
            logic [OUT_WIDTH-1:0] res;
            logic [OUT_WIDTH-1:0] data_d, data_q;
            logic                 sat_d, sat_q;
            logic                 lane_unused;

            // S1: extend the lane and add the rounding increment for this beat's mode
            always_comb begin
                lane_in  = i_data[k*IN_WIDTH +: IN_WIDTH];
                lane_x   = IS_SIGNED ? {lane_in[IN_WIDTH-1], lane_in} : {1'b0, lane_in};
                lane_add = '0;
                case (i_mode)
                    MODE_TRUNC: lane_add = '0;
                    MODE_HALFU: lane_add = C_HALF;
                    MODE_CONV:  lane_add = {{(EW-D){1'b0}}, lane_x[D], {(D-1){!lane_x[D]}}};
                    MODE_HALFA: lane_add = (IS_SIGNED && lane_x[EW-1]) ? C_HALF_M1 : C_HALF;
                    default:    lane_add = '0;
                endcase
                sum_d = s1_take ? (lane_x + lane_add) : sum_q;
            end

            // S2: take the kept bits, detect overflow, then clamp or wrap
            always_comb begin
                r   = sum_q[IN_WIDTH:D];
                ovf = IS_SIGNED ? (r[OUT_WIDTH] != r[OUT_WIDTH-1]) : r[OUT_WIDTH];
                res = r[OUT_WIDTH-1:0];
                if (ovf && s1_sat_en_q) begin
                    if (IS_SIGNED) begin
                        res = r[OUT_WIDTH] ? C_SMIN : C_SMAX;
                    end else begin
                        res = C_UMAX;
                    end
                end
                data_d = s2_take ? res : data_q;
                sat_d  = s2_take ? ovf : sat_q;
            end

            // The dropped fraction bits only matter through the carry they produced
            assign lane_unused = ^sum_q[D-1:0];

            assign o_data[k*OUT_WIDTH +: OUT_WIDTH] = data_q;
            assign o_sat[k]                         = sat_q;

            // Per-lane datapath registers; outputs hold while the stage is stalled
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sum_q  <= '0;
                    data_q <= '0;
                    sat_q  <= 1'b0;
                end else begin
                    sum_q  <= sum_d;
                    data_q <= data_d;
                    sat_q  <= sat_d;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
